pixel_substitutor: RTL and testbench

- Downstream consumer of the chaotic S-box generator: captures the 256 S-box bytes as the generator writes them, then encrypts an 8-bit pixel stream.
- Cipher rule is substitution plus CBC-style diffusion: C[i] = SBOX[P[i] XOR K[i]] XOR C[i-1], with C[-1] = IV.
- K[i] is a chaotic keystream byte supplied alongside each pixel, taken from the mixer low byte.
- Output is a valid/ready byte stream with end-of-frame marking.

---
 rtl/pixel_substitutor.sv | 150 +++++++++++++++
 tb/tb_pixel_substitutor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_substitutor.sv
`default_nettype none
// ============================================================================
// pixel_substitutor: captures a 256-entry S-box, then encrypts pixels as
// C[i] = SBOX[P[i] ^ K[i]] ^ C[i-1] (C[-1] = IV).   Rev 1.0
// ============================================================================
module pixel_substitutor #(
  parameter int unsigned NUM_PIXELS = 65536,
  parameter logic [7:0]  IV         = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sb_wr_en,
  input  logic [7:0] sb_wr_data,
  input  logic       sb_done,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_data,
  input  logic [7:0] key_data,
  output logic       c_valid,
  input  logic       c_ready,
  output logic [7:0] c_data,
  output logic       c_last,
  output logic       frame_done,
  output logic       sbox_err
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [19:0] LAST_IDX = 20'(NUM_PIXELS - 1);

  state_t      state_q, state_d;
  logic [8:0]  wr_cnt_q, wr_cnt_d;
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]  chain_q, chain_d;
  logic [7:0]  c_data_q, c_data_d;
  logic        c_valid_q, c_valid_d;
  logic        c_last_q, c_last_d;
  logic        frame_done_q, frame_done_d;
  logic        sbox_err_q, sbox_err_d;

  logic [7:0]  sbox_q [256];
  logic        sb_we;
  logic        accept;
  logic [7:0]  sub_byte;

  assign pix_ready  = (state_q == ST_RUN) && (!c_valid_q || c_ready);
  assign accept     = pix_valid && pix_ready;
  assign sb_we      = (state_q == ST_LOAD) && sb_wr_en;
  assign sub_byte   = sbox_q[pix_data ^ key_data] ^ chain_q;

  assign c_valid    = c_valid_q;
  assign c_data     = c_data_q;
  assign c_last     = c_last_q;
  assign frame_done = frame_done_q;
  assign sbox_err   = sbox_err_q;

  // Table storage carries no reset; a reset always forces a full reload.
  always_ff @(posedge clk) begin
    if (sb_we) begin
      sbox_q[wr_cnt_q[7:0]] <= sb_wr_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    chain_d      = chain_q;
    c_data_d     = c_data_q;
    c_valid_d    = c_valid_q;
    c_last_d     = c_last_q;
    frame_done_d = 1'b0;
    sbox_err_d   = sbox_err_q;

    case (state_q)
      ST_LOAD: begin
        if (sb_done && !wr_cnt_q[8]) begin
          sbox_err_d = 1'b1;
        end
        if (sb_wr_en) begin
          wr_cnt_d = wr_cnt_q + 9'd1;
          if (wr_cnt_q == 9'd255) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          c_data_d  = sub_byte;
          chain_d   = sub_byte;
          c_valid_d = 1'b1;
          pix_cnt_d = pix_cnt_q + 20'd1;
          if (pix_cnt_q == LAST_IDX) begin
            c_last_d = 1'b1;
            state_d  = ST_DRAIN;
          end
        end else if (c_valid_q && c_ready) begin
          c_valid_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        // Last byte leaves: rearm chaining for the next frame, keep the table.
        if (c_valid_q && c_ready && c_last_q) begin
          c_valid_d    = 1'b0;
          c_last_d     = 1'b0;
          frame_done_d = 1'b1;
          chain_d      = IV;
          pix_cnt_d    = 20'd0;
          state_d      = ST_RUN;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_LOAD;
      wr_cnt_q     <= 9'd0;
      pix_cnt_q    <= 20'd0;
      chain_q      <= IV;
      c_data_q     <= 8'd0;
      c_valid_q    <= 1'b0;
      c_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sbox_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      chain_q      <= chain_d;
      c_data_q     <= c_data_d;
      c_valid_q    <= c_valid_d;
      c_last_q     <= c_last_d;
      frame_done_q <= frame_done_d;
      sbox_err_q   <= sbox_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_substitutor.sv
`default_nettype none
// ============================================================================
// tb_pixel_substitutor: directed + randomized stimulus against a
// transaction-level cipher model.   Rev 1.0
// ============================================================================
module tb_pixel_substitutor;

  localparam int         NPIX = 3;
  localparam logic [7:0] IVV  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       sb_wr_en, sb_done, pix_valid, c_ready;
  logic [7:0] sb_wr_data, pix_data, key_data;
  logic       pix_ready, c_valid, c_last, frame_done, sbox_err;
  logic [7:0] c_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model: table contents, load progress, frame position,
  // and the single byte currently offered downstream.
  logic [7:0] m_sbox [256];
  int         m_wr;
  bit         m_loaded, m_draining, m_err, m_cv, m_cl, m_fd;
  logic [7:0] m_chain, m_cd;
  int         m_idx;

  pixel_substitutor #(.NUM_PIXELS(NPIX), .IV(IVV)) dut (
    .clk(clk), .rst(rst),
    .sb_wr_en(sb_wr_en), .sb_wr_data(sb_wr_data), .sb_done(sb_done),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .key_data(key_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .c_last(c_last), .frame_done(frame_done), .sbox_err(sbox_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_loaded = 0; m_draining = 0; m_err = 0;
    m_cv = 0; m_cl = 0; m_fd = 0; m_cd = 8'h00; m_chain = IVV; m_idx = 0;
  endtask

  function automatic bit exp_ready();
    return m_loaded && !m_draining && (!m_cv || c_ready);
  endfunction

  task automatic check_outputs();
    chk("pix_ready",  {7'd0, pix_ready},  {7'd0, exp_ready()});
    chk("c_valid",    {7'd0, c_valid},    {7'd0, m_cv});
    chk("c_data",     c_data,             m_cd);
    chk("c_last",     {7'd0, c_last},     {7'd0, m_cl});
    chk("frame_done", {7'd0, frame_done}, {7'd0, m_fd});
    chk("sbox_err",   {7'd0, sbox_err},   {7'd0, m_err});
  endtask

  task automatic tick();
    bit         acc;
    logic [7:0] c;
    acc = exp_ready() && pix_valid;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      m_fd = 0;
      if (!m_loaded) begin
        if (sb_done) m_err = 1;
        if (sb_wr_en) begin
          m_sbox[m_wr] = sb_wr_data;
          m_wr++;
          if (m_wr == 256) m_loaded = 1;
        end
      end else if (m_draining) begin
        if (m_cv && c_ready) begin
          m_cv = 0; m_cl = 0; m_fd = 1; m_chain = IVV; m_idx = 0; m_draining = 0;
        end
      end else if (acc) begin
        c = m_sbox[pix_data ^ key_data] ^ m_chain;
        m_chain = c; m_cd = c; m_cv = 1;
        m_cl = (m_idx == NPIX - 1);
        if (m_cl) m_draining = 1;
        m_idx++;
      end else if (m_cv && c_ready) begin
        m_cv = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    sb_wr_en = 0; sb_wr_data = 0; sb_done = 0;
    pix_valid = 0; pix_data = 0; key_data = 0; c_ready = 1;
  endtask

  // mode 0: identity, 1: inverted, 2: random
  task automatic load_sbox(input int mode, input int count);
    for (int i = 0; i < count; i++) begin
      sb_wr_en = 1;
      sb_wr_data = (mode == 0) ? 8'(i) : (mode == 1) ? ~8'(i) : 8'($urandom);
      tick();
    end
    sb_wr_en = 0;
  endtask

  task automatic send(input logic [7:0] p, input logic [7:0] k);
    pix_valid = 1; pix_data = p; key_data = k; c_ready = 1;
    tick();
    pix_valid = 0;
  endtask

  task automatic run_rand(input int n, input int pv_pct, input int cr_pct);
    for (int i = 0; i < n; i++) begin
      pix_valid = ($urandom_range(99) < pv_pct);
      c_ready   = ($urandom_range(99) < cr_pct);
      pix_data  = 8'($urandom);
      key_data  = 8'($urandom);
      tick();
    end
    pix_valid = 0; c_ready = 1;
  endtask

  initial begin
    logic [7:0] held;
    idle_inputs();
    model_reset();
    rst = 0;
    tick(); tick();
    chk("reset_c_data", c_data, 8'h00);
    rst = 1;

    // Identity table, zero key
    load_sbox(0, 256);
    tick();
    send(8'h12, 8'h00);
    chk("id_c0", c_data, 8'h12 ^ IVV);
    send(8'h34, 8'h00);
    chk("id_c1", c_data, 8'h34 ^ 8'h12 ^ IVV);
    send(8'h56, 8'h00);
    tick(); tick();

    // Inverted table, two frames of the 0x5A pattern
    rst = 0; tick(); rst = 1;
    load_sbox(1, 256);
    for (int f = 0; f < 2; f++) begin
      send(8'h00, 8'h00); chk("inv_c0", c_data, 8'h5A);
      send(8'h0F, 8'hF0); chk("inv_c1", c_data, 8'h5A);
      send(8'hFF, 8'h00); chk("inv_c2", c_data, 8'h5A);
      chk("inv_last", {7'd0, c_last}, 8'h01);
      tick();
      chk("inv_done", {7'd0, frame_done}, 8'h01);
    end

    // Backpressure: hold c_ready low with a pixel pending
    pix_valid = 1; pix_data = 8'h3C; key_data = 8'h11; c_ready = 1;
    tick();
    held = c_data;
    c_ready = 0; pix_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", c_data, held);
    end
    c_ready = 1;
    for (int i = 0; i < 8; i++) begin
      pix_data = 8'($urandom); key_data = 8'($urandom);
      tick();
    end
    pix_valid = 0;
    tick(); tick();
    run_rand(200, 70, 60);
    run_rand(60, 100, 100);
    tick(); tick();

    // Early done, then protection of the table after load
    rst = 0; tick(); rst = 1;
    load_sbox(2, 100);
    sb_done = 1; tick(); sb_done = 0;
    chk("err_set", {7'd0, sbox_err}, 8'h01);
    load_sbox(2, 156);
    load_sbox(2, 44);
    sb_done = 1; tick(); sb_done = 0;
    for (int i = 0; i < 64; i++) begin
      pix_valid = 1; pix_data = 8'(i * 4 + 1); key_data = 8'h00; c_ready = 1;
      tick();
    end
    pix_valid = 0;
    run_rand(100, 60, 70);
    tick(); tick();

    // Reset in the middle of a frame
    rst = 0; tick(); rst = 1;
    load_sbox(2, 256);
    send(8'hAA, 8'h55);
    send(8'h01, 8'h02);
    pix_valid = 1; c_ready = 1; rst = 0;
    tick();
    chk("mid_rst_valid", {7'd0, c_valid}, 8'h00);
    rst = 1;
    for (int i = 0; i < 10; i++) tick();
    pix_valid = 0;
    load_sbox(2, 255);
    pix_valid = 1;
    tick();
    chk("reload_ready", {7'd0, pix_ready}, 8'h00);
    pix_valid = 0;
    load_sbox(2, 1);
    run_rand(80, 80, 80);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
